simple_cpu_datapath: RTL and testbench



---
 rtl/simple_cpu_datapath.sv | 178 +++++++++++++++++
 tb/tb_simple_cpu_datapath.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_cpu_datapath.sv
// Bus-based 32-bit CPU datapath: registers, PC, IR, MAR, MDR, Y, 64-bit Z and an ALU
// sharing one bus whose source is chosen by a lowest-bit-wins priority encoder.
module simple_cpu_datapath (
   input  logic        Clock,
   input  logic        Clear,
   input  logic        PCout,
   input  logic        Zlowout,
   input  logic        ZHighout,
   input  logic        MDRout,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        Cout,
   input  logic        InPortout,
   input  logic        R0out,
   input  logic        R1out,
   input  logic        R2out,
   input  logic        R3out,
   input  logic        R4out,
   input  logic        R5out,
   input  logic        R6out,
   input  logic        R7out,
   input  logic        R8out,
   input  logic        R9out,
   input  logic        R10out,
   input  logic        R11out,
   input  logic        R12out,
   input  logic        R13out,
   input  logic        R14out,
   input  logic        R15out,
   input  logic        MARin,
   input  logic        Zin,
   input  logic        PCin,
   input  logic        MDRin,
   input  logic        IRin,
   input  logic        Yin,
   input  logic        R3in,
   input  logic        R4in,
   input  logic        R7in,
   input  logic        IncPC,
   input  logic        Read,
   input  logic        AND,
   input  logic [31:0] Mdatain,
   input  logic [4:0]  operation,
   output logic [31:0] encoder_input
);

   typedef enum logic [4:0] {
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_SHR  = 5'b00101,
      OP_SHL  = 5'b00110,
      OP_AND  = 5'b00111,
      OP_OR   = 5'b01000,
      OP_ROR  = 5'b01001,
      OP_ROL  = 5'b01010,
      OP_SHRA = 5'b01011,
      OP_MUL  = 5'b01111,
      OP_DIV  = 5'b10000,
      OP_NEG  = 5'b10001,
      OP_NOT  = 5'b10010
   } alu_op_t;

   logic [31:0] r3, r4, r7, pc, ir, mar, mdr, y, z_high, z_low;
   logic [31:0] bus;
   logic [31:0] c_value;
   logic [4:0]  bus_select;
   logic        select_valid;
   logic [63:0] alu_result;
   logic [4:0]  shift;
   logic signed [63:0] product;
   logic signed [31:0] quotient, remainder;
   logic        unused_bits;

   assign encoder_input = {8'h00, Cout, InPortout, MDRout, PCout, Zlowout, ZHighout, LOout, HIout,
                           R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                           R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

   assign c_value = {{13{ir[18]}}, ir[18:0]};

   // MAR feeds the memory side only and the upper IR bits are decoded elsewhere.
   assign unused_bits = ^{mar, ir[31:19]};

   // Scanning downward lets the lowest asserted strobe overwrite higher ones.
   always_comb begin
      bus_select   = 5'd0;
      select_valid = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (encoder_input[i]) begin
            bus_select   = 5'(i);
            select_valid = 1'b1;
         end
      end
   end

   always_comb begin
      bus = 32'h0000_0000;
      if (select_valid) begin
         case (bus_select)
            5'd3:    bus = r3;
            5'd4:    bus = r4;
            5'd7:    bus = r7;
            5'd18:   bus = z_high;
            5'd19:   bus = z_low;
            5'd20:   bus = pc;
            5'd21:   bus = mdr;
            5'd23:   bus = c_value;
            default: bus = 32'h0000_0000;
         endcase
      end
   end

   assign shift   = bus[4:0];
   assign product = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});

   always_comb begin
      quotient  = 32'sd0;
      remainder = 32'sd0;
      if (bus != 32'h0000_0000) begin
         quotient  = $signed(y) / $signed(bus);
         remainder = $signed(y) % $signed(bus);
      end
   end

   always_comb begin
      alu_result = 64'h0;
      if (IncPC) begin
         alu_result = {32'h0, bus + 32'd1};
      end else if (AND) begin
         alu_result = {32'h0, y & bus};
      end else begin
         case (operation)
            OP_ADD:  alu_result = {32'h0, y + bus};
            OP_SUB:  alu_result = {32'h0, y - bus};
            OP_SHR:  alu_result = {32'h0, y >> shift};
            OP_SHL:  alu_result = {32'h0, y << shift};
            OP_AND:  alu_result = {32'h0, y & bus};
            OP_OR:   alu_result = {32'h0, y | bus};
            OP_ROR:  alu_result = {32'h0, (y >> shift) | (y << (6'd32 - {1'b0, shift}))};
            OP_ROL:  alu_result = {32'h0, (y << shift) | (y >> (6'd32 - {1'b0, shift}))};
            OP_SHRA: alu_result = {32'h0, 32'($signed(y) >>> shift)};
            OP_MUL:  alu_result = product;
            OP_DIV:  alu_result = {remainder, quotient};
            OP_NEG:  alu_result = {32'h0, 32'd0 - bus};
            OP_NOT:  alu_result = {32'h0, ~bus};
            default: alu_result = 64'h0;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         r3     <= '0;
         r4     <= '0;
         r7     <= '0;
         pc     <= '0;
         ir     <= '0;
         mar    <= '0;
         mdr    <= '0;
         y      <= '0;
         z_high <= '0;
         z_low  <= '0;
      end else begin
         if (R3in)  r3  <= bus;
         if (R4in)  r4  <= bus;
         if (R7in)  r7  <= bus;
         if (PCin)  pc  <= bus;
         if (IRin)  ir  <= bus;
         if (MARin) mar <= bus;
         if (Yin)   y   <= bus;
         if (MDRin) mdr <= Read ? Mdatain : bus;
         if (Zin) begin
            z_high <= alu_result[63:32];
            z_low  <= alu_result[31:0];
         end
      end
   end

endmodule

// File: tb/tb_simple_cpu_datapath.sv
// Directed bench for simple_cpu_datapath: drives control strobes cycle by cycle and
// compares internal registers and the bus against hand-computed values.
module tb_simple_cpu_datapath;

   logic        Clock;
   logic        Clear;
   logic        PCout, Zlowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout;
   logic [15:0] r_out;
   logic        MARin, Zin, PCin, MDRin, IRin, Yin, R3in, R4in, R7in;
   logic        IncPC, Read, AND;
   logic [31:0] Mdatain;
   logic [4:0]  operation;
   logic [31:0] encoder_input;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  op;
      logic [31:0] lo;
      logic [31:0] hi;
      string       name;
   } alu_vec_t;

   alu_vec_t vecs [15];

   simple_cpu_datapath dut (
      .Clock(Clock), .Clear(Clear),
      .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
      .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
      .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
      .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
      .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
      .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .R3in(R3in), .R4in(R4in), .R7in(R7in),
      .IncPC(IncPC), .Read(Read), .AND(AND),
      .Mdatain(Mdatain), .operation(operation),
      .encoder_input(encoder_input)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clear_strobes();
      PCout = 0; Zlowout = 0; ZHighout = 0; MDRout = 0; HIout = 0; LOout = 0;
      Cout = 0; InPortout = 0; r_out = '0;
      MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
      R3in = 0; R4in = 0; R7in = 0; IncPC = 0; Read = 0; AND = 0;
      Mdatain = '0; operation = '0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic mdr_load(input logic [31:0] d);
      clear_strobes();
      Read = 1; MDRin = 1; Mdatain = d;
      tick();
      clear_strobes();
   endtask

   task automatic load_reg(input logic [31:0] d, input int which);
      mdr_load(d);
      MDRout = 1;
      if (which == 3) R3in = 1;
      else if (which == 4) R4in = 1;
      else R7in = 1;
      tick();
      clear_strobes();
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      load_reg(a, 3);
      load_reg(b, 7);
      r_out[3] = 1; Yin = 1;
      tick();
      clear_strobes();
      r_out[7] = 1; operation = op; Zin = 1;
      tick();
      clear_strobes();
   endtask

   task automatic test_reset();
      logic [31:0] obs [10];
      string names [10];
      load_reg(32'h55, 3);
      load_reg(32'h66, 4);
      load_reg(32'h77, 7);
      MDRout = 1; PCin = 1; IRin = 1; Yin = 1; MARin = 1;
      tick();
      clear_strobes();
      r_out[7] = 1; operation = 5'b00011; Zin = 1;
      tick();
      clear_strobes();
      #2 Clear = 0;
      #1;
      obs = '{dut.r3, dut.r4, dut.r7, dut.pc, dut.ir, dut.mdr, dut.z_low, dut.z_high, dut.y, dut.bus};
      names = '{"r3", "r4", "r7", "pc", "ir", "mdr", "z_low", "z_high", "y", "bus"};
      for (int i = 0; i < 10; i++) begin
         tests_run++;
         if (obs[i] !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_%s: got %h expected %h", names[i], obs[i], 32'h0);
         end
      end
      #2 Clear = 1;
   endtask

   task automatic test_loads();
      load_reg(32'h22, 3);
      tests_run++;
      if (dut.r3 !== 32'h22) begin
         tests_failed++;
         $display("[TB] FAIL load_r3: got %h expected %h", dut.r3, 32'h22);
      end
      load_reg(32'h24, 7);
      tests_run++;
      if (dut.r7 !== 32'h24) begin
         tests_failed++;
         $display("[TB] FAIL load_r7: got %h expected %h", dut.r7, 32'h24);
      end
      load_reg(32'h28, 4);
      tests_run++;
      if (dut.r4 !== 32'h28) begin
         tests_failed++;
         $display("[TB] FAIL load_r4: got %h expected %h", dut.r4, 32'h28);
      end
      tests_run++;
      if (dut.mdr !== 32'h28) begin
         tests_failed++;
         $display("[TB] FAIL load_mdr: got %h expected %h", dut.mdr, 32'h28);
      end
   endtask

   task automatic test_and();
      r_out[3] = 1; Yin = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.y !== 32'h22) begin
         tests_failed++;
         $display("[TB] FAIL and_y: got %h expected %h", dut.y, 32'h22);
      end
      // ADD is also selected; the AND strobe has to win.
      r_out[7] = 1; AND = 1; operation = 5'b00011; Zin = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.z_low !== 32'h20 || dut.z_high !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL and_z: got %h_%h expected %h_%h", dut.z_high, dut.z_low, 32'h0, 32'h20);
      end
      Zlowout = 1; R4in = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.r4 !== 32'h20) begin
         tests_failed++;
         $display("[TB] FAIL and_r4: got %h expected %h", dut.r4, 32'h20);
      end
   endtask

   task automatic test_ror();
      run_op(32'h22, 32'h4, 5'b01001);
      tests_run++;
      if (dut.z_low !== 32'h2000_0002 || dut.z_high !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL ror: got %h_%h expected %h_%h", dut.z_high, dut.z_low, 32'h0, 32'h2000_0002);
      end
   endtask

   task automatic test_mul_div();
      run_op(32'h22, 32'h24, 5'b01111);
      tests_run++;
      if (dut.z_low !== 32'h4C8 || dut.z_high !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL mul: got %h_%h expected %h_%h", dut.z_high, dut.z_low, 32'h0, 32'h4C8);
      end
      run_op(32'hFFFF_FFF9, 32'h2, 5'b10000);
      tests_run++;
      if (dut.z_low !== 32'hFFFF_FFFD || dut.z_high !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("[TB] FAIL div: got %h_%h expected %h_%h", dut.z_high, dut.z_low, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      end
      run_op(32'h10, 32'h0, 5'b10000);
      tests_run++;
      if (dut.z_low !== 32'h0 || dut.z_high !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL div_zero: got %h_%h expected %h_%h", dut.z_high, dut.z_low, 32'h0, 32'h0);
      end
   endtask

   task automatic test_alu_ops();
      vecs = '{
         '{32'h5,         32'h3,  5'b00011, 32'h8,         32'h0,         "add"},
         '{32'h5,         32'h7,  5'b00100, 32'hFFFF_FFFE, 32'h0,         "sub"},
         '{32'h8000_0000, 32'h4,  5'b00101, 32'h0800_0000, 32'h0,         "shr"},
         '{32'h10,        32'h21, 5'b00101, 32'h8,         32'h0,         "shr_low5"},
         '{32'h1,         32'd31, 5'b00110, 32'h8000_0000, 32'h0,         "shl"},
         '{32'hF0F0,      32'hFF00, 5'b00111, 32'hF000,    32'h0,         "and_op"},
         '{32'hF0,        32'h0F, 5'b01000, 32'hFF,        32'h0,         "or"},
         '{32'h8000_0001, 32'h1,  5'b01010, 32'h3,         32'h0,         "rol"},
         '{32'h1,         32'h0,  5'b01001, 32'h1,         32'h0,         "ror_zero"},
         '{32'h8000_0000, 32'h4,  5'b01011, 32'hF800_0000, 32'h0,         "shra"},
         '{32'hFFFF_FFFE, 32'h3,  5'b01111, 32'hFFFF_FFFA, 32'hFFFF_FFFF, "mul_neg"},
         '{32'h9,         32'h5,  5'b10001, 32'hFFFF_FFFB, 32'h0,         "neg"},
         '{32'h0,         32'h0,  5'b10010, 32'hFFFF_FFFF, 32'h0,         "not"},
         '{32'h5,         32'h3,  5'b00000, 32'h0,         32'h0,         "op_00000"},
         '{32'h5,         32'h3,  5'b11111, 32'h0,         32'h0,         "op_11111"}
      };
      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op);
         tests_run++;
         if (dut.z_low !== vecs[i].lo || dut.z_high !== vecs[i].hi) begin
            tests_failed++;
            $display("[TB] FAIL alu_%s: got %h_%h expected %h_%h",
                     vecs[i].name, dut.z_high, dut.z_low, vecs[i].hi, vecs[i].lo);
         end
      end
   endtask

   task automatic test_priority();
      mdr_load(32'h40);
      MDRout = 1; PCin = 1;
      tick();
      clear_strobes();
      mdr_load(32'h99);
      PCout = 1; MDRout = 1;
      #1;
      tests_run++;
      if (dut.bus !== 32'h40) begin
         tests_failed++;
         $display("[TB] FAIL prio_pc_mdr: got %h expected %h", dut.bus, 32'h40);
      end
      tests_run++;
      if (encoder_input !== 32'h0030_0000) begin
         tests_failed++;
         $display("[TB] FAIL encoder_map: got %h expected %h", encoder_input, 32'h0030_0000);
      end
      r_out[0] = 1;
      #1;
      tests_run++;
      if (dut.bus !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL prio_r0: got %h expected %h", dut.bus, 32'h0);
      end
      clear_strobes();
      HIout = 1; MDRout = 1;
      #1;
      tests_run++;
      if (dut.bus !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL prio_hi: got %h expected %h", dut.bus, 32'h0);
      end
      HIout = 0;
      #1;
      tests_run++;
      if (dut.bus !== 32'h99) begin
         tests_failed++;
         $display("[TB] FAIL bus_mdr: got %h expected %h", dut.bus, 32'h99);
      end
      clear_strobes();
   endtask

   task automatic test_pc_inc();
      // IncPC must override both AND and a MUL opcode.
      PCout = 1; IncPC = 1; AND = 1; operation = 5'b01111; Zin = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.z_low !== 32'h41 || dut.z_high !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL incpc_z: got %h_%h expected %h_%h", dut.z_high, dut.z_low, 32'h0, 32'h41);
      end
      Zlowout = 1; PCin = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.pc !== 32'h41) begin
         tests_failed++;
         $display("[TB] FAIL pc_inc: got %h expected %h", dut.pc, 32'h41);
      end
      mdr_load(32'hFFFF_FFFF);
      MDRout = 1; PCin = 1;
      tick();
      clear_strobes();
      PCout = 1; IncPC = 1; Zin = 1;
      tick();
      clear_strobes();
      Zlowout = 1; PCin = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.pc !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL pc_wrap: got %h expected %h", dut.pc, 32'h0);
      end
   endtask

   task automatic test_ir_cout();
      mdr_load(32'h2A2B_8000);
      MDRout = 1; IRin = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.ir !== 32'h2A2B_8000) begin
         tests_failed++;
         $display("[TB] FAIL ir_load: got %h expected %h", dut.ir, 32'h2A2B_8000);
      end
      Cout = 1;
      #1;
      tests_run++;
      if (dut.bus !== 32'h0003_8000) begin
         tests_failed++;
         $display("[TB] FAIL cout_pos: got %h expected %h", dut.bus, 32'h0003_8000);
      end
      clear_strobes();
      mdr_load(32'h0007_FFFF);
      MDRout = 1; IRin = 1;
      tick();
      clear_strobes();
      Cout = 1;
      #1;
      tests_run++;
      if (dut.bus !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("[TB] FAIL cout_neg: got %h expected %h", dut.bus, 32'hFFFF_FFFF);
      end
      clear_strobes();
   endtask

   task automatic test_back_to_back();
      mdr_load(32'h11);
      MDRout = 1; Read = 1; MDRin = 1; Mdatain = 32'h77; R3in = 1; R4in = 1; Yin = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.r3 !== 32'h11 || dut.r4 !== 32'h11 || dut.y !== 32'h11) begin
         tests_failed++;
         $display("[TB] FAIL multi_load: got r3=%h r4=%h y=%h expected %h", dut.r3, dut.r4, dut.y, 32'h11);
      end
      tests_run++;
      if (dut.mdr !== 32'h77) begin
         tests_failed++;
         $display("[TB] FAIL mdr_self_swap: got %h expected %h", dut.mdr, 32'h77);
      end
      r_out[3] = 1; R3in = 1; R7in = 1;
      tick();
      clear_strobes();
      tests_run++;
      if (dut.r3 !== 32'h11 || dut.r7 !== 32'h11) begin
         tests_failed++;
         $display("[TB] FAIL self_load: got r3=%h r7=%h expected %h", dut.r3, dut.r7, 32'h11);
      end
   endtask

   task automatic test_clear_mid();
      load_reg(32'h33, 3);
      load_reg(32'h5, 7);
      r_out[3] = 1; Yin = 1;
      tick();
      clear_strobes();
      r_out[7] = 1; operation = 5'b00011; Zin = 1;
      #2 Clear = 0;
      #1;
      tests_run++;
      if (dut.y !== 32'h0 || dut.r3 !== 32'h0 || dut.r7 !== 32'h0 || dut.z_low !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL clear_mid: got y=%h r3=%h r7=%h z_low=%h expected %h",
                  dut.y, dut.r3, dut.r7, dut.z_low, 32'h0);
      end
      clear_strobes();
      #1 Clear = 1;
      tick();
      tests_run++;
      if (dut.z_low !== 32'h0 || dut.y !== 32'h0 || dut.bus !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL clear_release: got z_low=%h y=%h bus=%h expected %h",
                  dut.z_low, dut.y, dut.bus, 32'h0);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      clear_strobes();
      Clear = 1'b0;
      #12 Clear = 1'b1;
      test_reset();
      test_loads();
      test_and();
      test_ror();
      test_mul_div();
      test_alu_ops();
      test_priority();
      test_pc_inc();
      test_ir_cout();
      test_back_to_back();
      test_clear_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
